// File: rtl/pencoder_pkg.sv
// Shared constants, state type and width helper for the pencoder_rr arbiter.
// Optional contention statistics are enabled with the PENC_STATS_EN macro.
package pencoder_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   CNT_W      = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // ceil(log2(n)) for n >= 2
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = r + (((32'sd1 << i) < n) ? 32'sd1 : 32'sd0);
        end
        return r;
    endfunction

endpackage

// File: rtl/pencoder_core.sv
// Combinational circular search: first set request at start, start-1, ... (mod N).
module pencoder_core
    import pencoder_pkg::*;
#(
    parameter int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        int pos;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int off = N - 1; off >= 0; off--) begin
            pos   = (int'(start) + N - off) % N;
            idx   = req[W'(pos)] ? W'(pos) : idx;
            found = found | req[W'(pos)];
        end
    end

endmodule

// File: rtl/pencoder_rr.sv
// N-input fixed/round-robin arbiter with a registered valid/ready output stage.
// Define PENC_STATS_EN to add the saturating contention_cnt output.
module pencoder_rr
    import pencoder_pkg::*;
#(
    parameter int N = 8,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] y,
    output logic [N-1:0] grant,
    output logic         any
`ifdef PENC_STATS_EN
    ,
    output logic [CNT_W-1:0] contention_cnt
`endif
);

    localparam logic [N-1:0] GRANT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] IDX_TOP   = W'(N - 1);

    out_state_t     r_state;
    out_state_t     w_state_nxt;
    logic [W-1:0]   r_y;
    logic [N-1:0]   r_grant;
    logic [W-1:0]   r_ptr;

    logic           w_load;
    logic           w_accept;
    logic [W-1:0]   w_ptr_eff;
    logic [W-1:0]   w_start;
    logic [W-1:0]   w_idx;
    logic           w_found;

    assign w_load   = (r_state == ST_EMPTY) || out_ready;
    assign w_accept = (r_state == ST_FULL) && out_ready;

    // An accept in this cycle moves the pointer before the reload search.
    assign w_ptr_eff = w_accept ? r_y : r_ptr;

    // Search start: top index in fixed mode, one below the pointer in RR mode.
    always_comb begin
        w_start = IDX_TOP;
        if (mode == MODE_RR) begin
            if (w_ptr_eff == '0) begin
                w_start = IDX_TOP;
            end else begin
                w_start = w_ptr_eff - W'(1);
            end
        end else begin
            w_start = IDX_TOP;
        end
    end

    pencoder_core #(
        .N (N)
    ) u_core (
        .req   (req),
        .start (w_start),
        .idx   (w_idx),
        .found (w_found)
    );

    // Output stage next state: reload on load, otherwise hold.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            if (w_found) begin
                w_state_nxt = ST_FULL;
            end else begin
                w_state_nxt = ST_EMPTY;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Output registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_y     <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr <= r_y;
            end
            if (w_load) begin
                r_y     <= w_found ? w_idx : '0;
                r_grant <= w_found ? (GRANT_ONE << w_idx) : '0;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign y         = r_y;
    assign grant     = r_grant;
    assign any       = |req;

`ifdef PENC_STATS_EN
    logic             r_multi;
    logic [CNT_W-1:0] r_cnt;

    // Remember whether the loaded result had competitors; count on its accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_multi <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept && r_multi && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_multi <= (req & (req - N'(1))) != '0;
            end
        end
    end

    assign contention_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_pencoder_rr.sv
// Self-checking bench for pencoder_rr: directed vector table, corner sequences,
// and randomized traffic against a behavioural arbiter model.
module tb_pencoder_rr;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mode;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] y;
    logic [7:0] grant;
    logic       any;
`ifdef PENC_STATS_EN
    logic [15:0] contention_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model state
    int m_valid;
    int m_y;
    int m_ptr;
    int m_multi;
    int m_cnt;

    pencoder_rr #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .y         (y),
        .grant     (grant),
        .any       (any)
`ifdef PENC_STATS_EN
        ,
        .contention_cnt (contention_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [7:0] req;
        logic       rdy;
        logic       exp_v;
        logic [2:0] exp_y;
        logic [7:0] exp_g;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_winner(input logic [7:0] r, input logic m, input int ptr);
        int w;
        int c;
        w = -1;
        if (m == 1'b0) begin
            for (int k = 0; k < N; k++) if (r[k]) w = k;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (((ptr - k) % N) + N) % N;
                if (w < 0 && r[c]) w = c;
            end
        end
        return w;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int acc;
        int ld;
        if (rst) begin
            m_valid = 0; m_y = 0; m_ptr = 0; m_multi = 0; m_cnt = 0;
        end else begin
            acc = (m_valid != 0) && out_ready;
            ld  = (m_valid == 0) || out_ready;
            if (acc) begin
                m_ptr = m_y;
                if (m_multi != 0 && m_cnt < 65535) m_cnt++;
            end
            if (ld) begin
                if (req != 8'd0) begin
                    m_y = ref_winner(req, mode, m_ptr);
                    m_valid = 1;
                    m_multi = ($countones(req) > 1) ? 1 : 0;
                end else begin
                    m_valid = 0;
                    m_y = 0;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, int'(out_valid), m_valid);
        chk({tag, ".y"}, int'(y), (m_valid != 0) ? m_y : 0);
        chk({tag, ".grant"}, int'(grant), (m_valid != 0) ? (1 << m_y) : 0);
        chk({tag, ".any"}, int'(any), (req != 8'd0) ? 1 : 0);
`ifdef PENC_STATS_EN
        chk({tag, ".cnt"}, int'(contention_cnt), m_cnt);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 8'd0; mode = 1'b0; out_ready = 1'b1;

        //              rst   mode  req           rdy   v     y     grant
        tbl[0]  = '{1'b1, 1'b0, 8'h00,        1'b1, 1'b0, 3'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 8'b0010_0110, 1'b1, 1'b1, 3'd5, 8'h20};
        tbl[2]  = '{1'b0, 1'b0, 8'h01,        1'b1, 1'b1, 3'd0, 8'h01};
        tbl[3]  = '{1'b0, 1'b0, 8'h01,        1'b0, 1'b1, 3'd0, 8'h01};
        tbl[4]  = '{1'b0, 1'b0, 8'h80,        1'b0, 1'b1, 3'd0, 8'h01};
        tbl[5]  = '{1'b0, 1'b0, 8'h80,        1'b0, 1'b1, 3'd0, 8'h01};
        tbl[6]  = '{1'b0, 1'b0, 8'h80,        1'b0, 1'b1, 3'd0, 8'h01};
        tbl[7]  = '{1'b0, 1'b0, 8'h80,        1'b1, 1'b1, 3'd7, 8'h80};
        tbl[8]  = '{1'b0, 1'b0, 8'h00,        1'b1, 1'b0, 3'd0, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 8'h00,        1'b1, 1'b0, 3'd0, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 8'b1000_0101, 1'b1, 1'b1, 3'd7, 8'h80};
        tbl[11] = '{1'b0, 1'b1, 8'b1000_0101, 1'b1, 1'b1, 3'd2, 8'h04};
        tbl[12] = '{1'b0, 1'b1, 8'b1000_0101, 1'b1, 1'b1, 3'd0, 8'h01};
        tbl[13] = '{1'b0, 1'b1, 8'b1000_0101, 1'b1, 1'b1, 3'd7, 8'h80};
        tbl[14] = '{1'b0, 1'b1, 8'b1000_0101, 1'b1, 1'b1, 3'd2, 8'h04};
        tbl[15] = '{1'b1, 1'b1, 8'h00,        1'b1, 1'b0, 3'd0, 8'h00};
        tbl[16] = '{1'b0, 1'b1, 8'h03,        1'b1, 1'b1, 3'd1, 8'h02};
        tbl[17] = '{1'b0, 1'b1, 8'h03,        1'b1, 1'b1, 3'd0, 8'h01};
        tbl[18] = '{1'b0, 1'b1, 8'h03,        1'b1, 1'b1, 3'd1, 8'h02};
        tbl[19] = '{1'b0, 1'b1, 8'h03,        1'b1, 1'b1, 3'd0, 8'h01};
        tbl[20] = '{1'b0, 1'b0, 8'h03,        1'b1, 1'b1, 3'd1, 8'h02};
        tbl[21] = '{1'b0, 1'b0, 8'h03,        1'b1, 1'b1, 3'd1, 8'h02};
        tbl[22] = '{1'b0, 1'b0, 8'h03,        1'b1, 1'b1, 3'd1, 8'h02};
        tbl[23] = '{1'b0, 1'b0, 8'h40,        1'b1, 1'b1, 3'd6, 8'h40};
        tbl[24] = '{1'b0, 1'b0, 8'h40,        1'b0, 1'b1, 3'd6, 8'h40};
        tbl[25] = '{1'b1, 1'b0, 8'h40,        1'b0, 1'b0, 3'd0, 8'h00};
        tbl[26] = '{1'b0, 1'b1, 8'b1000_0101, 1'b1, 1'b1, 3'd7, 8'h80};

        @(posedge clk);
        #1;
        for (int i = 0; i < 27; i++) begin
            rst = tbl[i].rst; mode = tbl[i].mode; req = tbl[i].req; out_ready = tbl[i].rdy;
            cycle();
            chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(tbl[i].exp_v));
            chk($sformatf("vec%0d.y", i), int'(y), int'(tbl[i].exp_y));
            chk($sformatf("vec%0d.grant", i), int'(grant), int'(tbl[i].exp_g));
            chk($sformatf("vec%0d.any", i), int'(any), int'(|tbl[i].req));
        end

        // any follows req combinationally, without waiting for an edge
        req = 8'h10; #1;
        chk("any_comb_set", int'(any), 1);
        req = 8'h00; #1;
        chk("any_comb_clr", int'(any), 0);

        // randomized traffic against the model
        rst = 1'b1; out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'h01 << $urandom_range(0, 7);
                default: req = 8'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            check_model($sformatf("rnd%0d", i));
        end

`ifdef PENC_STATS_EN
        rst = 1'b1; mode = 1'b0; out_ready = 1'b1; req = 8'h00;
        cycle();
        rst = 1'b0;
        req = 8'h03; cycle();
        req = 8'h05; cycle();
        req = 8'h07; cycle();
        req = 8'h01; cycle();
        req = 8'h02; cycle();
        req = 8'h00; cycle();
        chk("stats_cnt3", int'(contention_cnt), 3);
        force dut.r_cnt = 16'hFFFF;
        #1;
        release dut.r_cnt;
        req = 8'h03; cycle();
        req = 8'h03; cycle();
        req = 8'h00; cycle();
        chk("stats_saturate", int'(contention_cnt), 65535);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pencoder_rr.md
Name: pencoder_rr

Overview:
Parametrised N-input priority encoder with a registered, handshaked output and a selectable fixed-priority or round-robin mode. Takes a request vector and outputs the winning index (binary) and a one-hot grant. The output is held stable until it is accepted. Used as a generic request arbiter in front of shared resources; generalises the 4:2 priority encoder to N inputs with fairness and flow control.

Parameters:
N, 8, number of request inputs; legal range 2..64.
W, derived localparam = ceil(log2(N)), width of the encoded index; not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  N  request vector; bit k = requester k
mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
out_ready  input  1  consumer accepts current result
out_valid  output  1  y/grant hold a valid result
y  output  W  encoded index of granted requester
grant  output  N  one-hot grant, equals 1<<y when out_valid, else 0
any  output  1  combinational OR of req (unregistered)

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, y=0, grant=0, ptr=0; with stats enabled, contention_cnt=0. Reset has priority over every other event, including a held, unaccepted result (that result is dropped).
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load condition: load = !out_valid || out_ready. On a load edge:
  - if req != 0: register winner, out_valid=1;
  - else: out_valid=0, y=0, grant=0.
  - Latency is 1 cycle from req to out_valid.
- Hold: while out_valid=1 and out_ready=0, y/grant/out_valid are frozen regardless of req or mode changes.
- Fixed mode: winner = highest set index of req, with no masking.
- Round-robin mode: search order is ptr-1, ptr-2, ..., 0, N-1, ..., ptr (mod N); the first set bit wins.
  - Because ptr=0 after reset, the first search starts at N-1, identical to fixed mode.
- ptr update: on accept (out_valid && out_ready), ptr <= y, in both modes. This keeps RR fair immediately after a mode switch.
- Accept-and-reload in the same cycle is allowed. The winner for the new load is computed using the updated ptr value (ptr = y being accepted), so back-to-back grants are fair with no bubble.
- Mode change takes effect on the next load only; ptr is not cleared.
- Single requester: granted every load cycle regardless of mode or ptr.
- Wrap-around: y=0 accepted in RR mode gives a next search start of N-1.
- No X outputs in any state.

Optional Feature:
PENC_STATS_EN. When defined, the block adds output port contention_cnt (16 bits). This counter increments on every accept where the request vector captured at load had more than one bit set. It saturates at 16'hFFFF and is cleared by rst. When not defined, the port and its logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package/include pencoder_pkg:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants;
  - clog2 function for W;
  - CNT_W=16 constant.
- One sub-module, pencoder_core: purely combinational N-input search. Inputs are req and a start index; outputs are idx[W-1:0] and found. It is instantiated once, with start = N-1 in fixed mode and ptr-1 (mod N) in RR mode.
- Registers and handshake logic live in pencoder_rr.

Test Plan:
- Reset, then fixed mode, out_ready=1, req=8'b0010_0110 -> next cycle out_valid=1, y=5, grant=8'b0010_0000; any=1 combinationally.
- Fixed mode, req=8'b0000_0001 held, out_ready=0 for 4 cycles, then req changes to 8'h80 -> y stays 0 and grant stays 8'h01 until out_ready=1. After accept, the next result is y=7.
- RR mode from reset, req=8'b1000_0101 held, out_ready=1 -> y sequence 7, 2, 0, 7, 2, with out_valid high every cycle.
- RR wrap: ptr=0 with req=8'b0000_0011 -> grants alternate 1, 0, 1, 0. Then switch to fixed mode -> 1, 1, 1.
- req=0 with out_ready=1 -> out_valid=0, y=0, grant=0 the next cycle. Assert rst while FULL and stalled -> outputs cleared the next cycle, and the first RR grant after reset starts the search at 7.
- PENC_STATS_EN: accept 3 results with multiple bits set in req and 2 results with a single bit -> contention_cnt=3. Force the counter to 16'hFFFF -> it stays at 16'hFFFF.
